// File: rtl/mc_sequencer_if.sv
// Control bus between the multicycle sequencer and the datapath / memory side.
// Carries the start/opcode/mem_ready inputs and the Moore control outputs.
// master: the sequencer (drives controls); slave: the datapath / environment.
interface mc_sequencer_if;
    logic        start;        // begin or resume execution
    logic [5:0]  opcode;       // instruction[31:26] at current PC
    logic        mem_ready;    // data memory access complete
    logic        regdst;       // rd (1) / rt (0) write-register select
    logic        jump;         // PC source is jump target
    logic        branch;       // PC source is branch target when zero
    logic        memread;      // data memory read enable
    logic        memtoreg;     // writeback source is memory data
    logic [1:0]  aluop;        // 00 add, 01 sub, 10 decode funct
    logic        memwrite;     // data memory write enable
    logic        alusrc;       // ALU operand B is immediate
    logic        regwrite;     // register file write strobe
    logic        pc_inc;       // retire strobe / load next PC
    logic        busy;         // executing (not IDLE/HALT)
    logic        halted;       // in HALT
    logic        fault;        // sticky memory-timeout flag
    logic [31:0] instr_count;  // retired instruction count

    modport master (
        input  start, opcode, mem_ready,
        output regdst, jump, branch, memread, memtoreg, aluop,
               memwrite, alusrc, regwrite, pc_inc, busy, halted,
               fault, instr_count
    );

    modport slave (
        output start, opcode, mem_ready,
        input  regdst, jump, branch, memread, memtoreg, aluop,
               memwrite, alusrc, regwrite, pc_inc, busy, halted,
               fault, instr_count
    );
endinterface

// File: rtl/mc_sequencer.sv
// Hardwired multicycle control FSM for a single-ALU MIPS-style datapath.
// Latency FETCH..retire: LW 5, SW 5, R-type 4, BEQ 3, JMP 3 (+ memory wait cycles).
// Backpressure: stalls in MEMRD/MEMWR until mem_ready; MEM_TIMEOUT waits -> HALT with fault.
// Ports: clk, rst_n (async active-low); bus (master modport) carries start/opcode/
// mem_ready in, and the Moore control bus, pc_inc, busy, halted, fault, instr_count out.
module mc_sequencer #(
    parameter logic [5:0]  OP_LW       = 6'h00,
    parameter logic [5:0]  OP_SW       = 6'h01,
    parameter logic [5:0]  OP_RTYPE    = 6'h02,
    parameter logic [5:0]  OP_BEQ      = 6'h04,
    parameter logic [5:0]  OP_JMP      = 6'h05,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_SWDONE,
        S_EXEC,
        S_RWB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        is_sw_q, is_sw_d;      // load/store direction captured at decode
    logic        fault_q, fault_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 8'd0;
            is_sw_q     <= 1'b0;
            fault_q     <= 1'b0;
            instr_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            is_sw_q     <= is_sw_d;
            fault_q     <= fault_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        is_sw_d    = is_sw_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMADR;
                    is_sw_d = 1'b0;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMADR;
                    is_sw_d = 1'b1;
                end else if (bus.opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (bus.opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (bus.opcode == OP_JMP) begin
                    state_d = S_JUMP;
                end else begin
                    // Illegal opcode halts without flagging a fault
                    state_d = S_HALT;
                end
            end
            S_MEMADR: begin
                // Clearing here means the counter is zero on entry to MEMRD/MEMWR
                wait_cnt_d = 8'd0;
                state_d    = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD, S_MEMWR: begin
                // Ready is tested first so a completion on the timeout cycle wins
                if (bus.mem_ready) begin
                    state_d = (state_q == S_MEMRD) ? S_MEMWB : S_SWDONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TIMEOUT_W) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                end
            end
            S_MEMWB, S_SWDONE, S_RWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_EXEC: state_d = S_RWB;
            S_HALT: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    fault_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode of the registered state only
    always_comb begin
        bus.regdst   = 1'b0;
        bus.jump     = 1'b0;
        bus.branch   = 1'b0;
        bus.memread  = 1'b0;
        bus.memtoreg = 1'b0;
        bus.aluop    = 2'b00;
        bus.memwrite = 1'b0;
        bus.alusrc   = 1'b0;
        bus.regwrite = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_MEMADR: bus.alusrc = 1'b1;
            S_MEMRD: begin
                bus.alusrc  = 1'b1;
                bus.memread = 1'b1;
            end
            S_MEMWB: begin
                bus.alusrc   = 1'b1;
                bus.memread  = 1'b1;
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                bus.alusrc   = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_SWDONE: retire = 1'b1;
            S_EXEC: begin
                bus.aluop  = 2'b10;
                bus.regdst = 1'b1;
            end
            S_RWB: begin
                bus.aluop    = 2'b10;
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                retire       = 1'b1;
            end
            S_BRANCH: begin
                bus.aluop  = 2'b01;
                bus.branch = 1'b1;
                retire     = 1'b1;
            end
            S_JUMP: begin
                bus.jump = 1'b1;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter wraps naturally at 2^32 and survives start
    assign instr_cnt_d     = instr_cnt_q + {31'd0, retire};

    assign bus.pc_inc      = retire;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fault       = fault_q;
    assign bus.instr_count = instr_cnt_q;

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Hardwired multicycle control FSM for the single-ALU MIPS-style datapath. It replaces the microcode ROM sequencer.
- Sequences every instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath control bus (regdst, jump, branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite) and the PC-advance strobe.
- Adds a memory-ready handshake with a timeout watchdog, a halt/fault state and a retired-instruction counter.

Parameters:
- OP_LW, 6'h00, load-word opcode
- OP_SW, 6'h01, store-word opcode
- OP_RTYPE, 6'h02, register ALU opcode; funct field is decoded by the datapath
- OP_BEQ, 6'h04, branch-if-equal opcode
- OP_JMP, 6'h05, jump opcode
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready before a fault; legal range 1..255

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin or resume execution; level sampled in IDLE or HALT
- opcode  in  6  instruction[31:26] from program memory at the current PC
- mem_ready  in  1  data memory has completed the access in progress
- regdst  out  1  write-register select: rd when 1, rt when 0
- jump  out  1  PC source is the jump target
- branch  out  1  PC source is the branch target when ALU zero is 1
- memread  out  1  data memory read enable
- memtoreg  out  1  register writeback source is memory data
- aluop  out  2  00 add, 01 subtract, 10 decode funct
- memwrite  out  1  data memory write enable
- alusrc  out  1  ALU operand B is the immediate
- regwrite  out  1  register file write strobe
- pc_inc  out  1  one-cycle strobe that retires the instruction and loads the next PC
- busy  out  1  FSM is executing, i.e. not in IDLE or HALT
- halted  out  1  FSM is in HALT
- fault  out  1  sticky flag: memory timeout caused the halt
- instr_count  out  32  number of retired instructions

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, wait counter=0, instr_count=0, fault=0. All control outputs, pc_inc, busy and halted are 0.
- Outputs are a Moore decode of the registered state. No output depends combinationally on opcode or mem_ready.
- IDLE: all outputs 0. If start=1, go to FETCH.
- FETCH: no controls asserted; opcode settles. Next state is DECODE.
- DECODE: branches on opcode.
  - OP_LW or OP_SW -> MEMADR
  - OP_RTYPE -> EXEC
  - OP_BEQ -> BRANCH
  - OP_JMP -> JUMP
  - any other value -> HALT with fault=0
- MEMADR: alusrc=1, aluop=00. LW goes to MEMRD; SW goes to MEMWR.
- MEMRD: alusrc=1, memread=1.
  - mem_ready=1 -> MEMWB.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, go to HALT and set fault=1.
- MEMWB: alusrc=1, memread=1, memtoreg=1, regwrite=1, pc_inc=1. Next state is FETCH.
- MEMWR: alusrc=1, memwrite=1.
  - mem_ready=1 -> pc_inc is asserted in this same cycle's successor, SWDONE.
  - The timeout rule is the same as in MEMRD.
- SWDONE: pc_inc=1. Next state is FETCH.
- EXEC: aluop=10, regdst=1. Next state is RWB.
- RWB: aluop=10, regdst=1, regwrite=1, pc_inc=1. Next state is FETCH.
- BRANCH: aluop=01, branch=1, pc_inc=1. Next state is FETCH.
- JUMP: jump=1, pc_inc=1. Next state is FETCH.
- HALT: halted=1, all controls 0.
  - start=1 -> FETCH and clear fault; the halt/fault cause is discarded.
  - Otherwise the FSM stays in HALT.
- Wait counter:
  - cleared on entry to MEMRD and MEMWR;
  - 8-bit;
  - if mem_ready=1 on the timeout cycle, ready wins and no fault is raised.
- Latency with mem_ready already 1, counted from FETCH up to and including the pc_inc cycle: LW 5, SW 5, R-type 4, BEQ 3, JMP 3.
- instr_count increments by 1 on every cycle with pc_inc=1. It wraps from 32'hFFFFFFFF to 0 and is not cleared by start.
- regwrite and pc_inc are high for exactly one cycle per instruction. The datapath uses their rising edges.
- start is ignored while busy=1.
- Reset asserted mid-instruction returns to IDLE immediately. No write strobe is held or completed.

Test Plan:
- Reset then start=1 one cycle, opcode=6'h00, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; MEMWB has memtoreg=1, regwrite=1, pc_inc=1; instr_count=1.
- Sequence opcodes 02, 04, 05 with one start pulse -> pc_inc every 4, 3, 3 cycles; aluop 10, 01, 00 in the respective execute states; instr_count=3.
- SW (opcode=6'h01) with mem_ready low 3 cycles -> memwrite held 4 cycles, then a single pc_inc, no fault.
- LW with mem_ready held low -> after 16 MEMRD cycles: halted=1, fault=1, pc_inc never asserted; start=1 -> fault=0, FETCH.
- Opcode 6'h3F after three valid instructions -> HALT, halted=1, fault=0, instr_count=3; outputs stable over 10 cycles.
- rst_n driven low asynchronously mid-MEMWR -> memwrite drops without a clock edge; instr_count=0; start is required to run again.
